hub75_rx_capture: RTL and testbench

HUB75_RX_CAPTURE -- requirements
Module: hub75_rx_capture

---
 rtl/hub75_pkg.sv | 24 ++
 rtl/hub75_in_sync.sv | 30 +++
 rtl/hub75_rx_capture.sv | 186 ++++++++++++++++++
 tb/tb_hub75_rx_capture.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
`timescale 1ns/1ps
// Shared types and width helpers for the HUB75 receive capture block.
package hub75_pkg;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } pix_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  function automatic int row_width_f(input int vpix, input int segs);
    return (vpix / segs > 1) ? $clog2(vpix / segs) : 1;
  endfunction

  function automatic int plane_width_f(input int bpp);
    return (bpp > 1) ? $clog2(bpp) : 1;
  endfunction

endpackage

// File: rtl/hub75_in_sync.sv
`timescale 1ns/1ps
// Two-flop synchronizer per input bit, plus a rising-edge detector on the synchronized level.
module hub75_in_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] s_p0, s_p1, s_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p0 <= '0;
      s_p1 <= '0;
      s_p2 <= '0;
    end else begin
      s_p0 <= d;
      s_p1 <= s_p0;
      s_p2 <= s_p1;
    end
  end

  assign q    = s_p1;
  assign rise = s_p1 & ~s_p2;

endmodule

// File: rtl/hub75_rx_capture.sv
`timescale 1ns/1ps
// HUB75 receive capture: samples the panel bus, assembles one line per latch and
// replays it column by column over a valid/ready write port tagged with row and bit-plane.
module hub75_rx_capture
  import hub75_pkg::*;
#(
  parameter int  hpixel_p    = 64,
  parameter int  vpixel_p    = 64,
  parameter int  bpp_p       = 8,
  parameter int  segments_p  = 2,
  localparam int addr_width  = $clog2(hpixel_p * vpixel_p),
  localparam int row_width   = row_width_f(vpixel_p, segments_p),
  localparam int plane_width = plane_width_f(bpp_p)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic                    O_CLK,
  input  logic                    STB,
  input  logic                    OE,
  input  logic                    A,
  input  logic                    B,
  input  logic                    C,
  input  logic                    D,
  input  logic                    E,
  input  logic                    R1,
  input  logic                    G1,
  input  logic                    B1,
  input  logic                    R2,
  input  logic                    G2,
  input  logic                    B2,
  output logic                    o_wr_valid,
  input  logic                    i_wr_ready,
  output logic [addr_width-1:0]   o_wr_addr,
  output logic [plane_width-1:0]  o_wr_plane,
  output logic [segments_p*3-1:0] o_wr_data,
  output logic                    o_len_err,
  output logic                    o_overrun,
  input  logic                    i_err_clr
);

  localparam int col_width = $clog2(hpixel_p + 1);
  localparam int idx_width = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam logic [col_width-1:0]   col_full   = col_width'(hpixel_p);
  localparam logic [idx_width-1:0]   col_last   = idx_width'(hpixel_p - 1);
  localparam logic [plane_width-1:0] plane_last = plane_width'(bpp_p - 1);

  typedef logic [segments_p*3-1:0] word_t;

  logic [13:0] sync_d, sync_q, sync_rise;
  pix_t [1:0]  pix_in;
  word_t       word_in;
  logic [4:0]  row_bits;
  logic [row_width-1:0] row_in;
  logic        clk_rise, stb_rise, latch_ok, unused_sync;

  assign sync_d = {OE, STB, O_CLK, E, D, C, B, A, R2, G2, B2, R1, G1, B1};

  hub75_in_sync #(.W(14)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sync_d),
    .q    (sync_q),
    .rise (sync_rise)
  );

  assign pix_in      = sync_q[5:0];
  assign word_in     = pix_in[segments_p-1:0];
  assign row_bits    = sync_q[10:6];
  assign row_in      = row_bits[row_width-1:0];
  assign clk_rise    = sync_rise[11];
  assign stb_rise    = sync_rise[12];
  // OE is carried through the synchronizer for timing symmetry only.
  assign unused_sync = ^{sync_q[13:11], sync_rise[13], sync_rise[10:0], row_bits};

  state_t                 state, state_nxt;
  logic [idx_width-1:0]   drain_col, drain_col_nxt;
  logic [col_width-1:0]   col_cnt;
  logic [row_width-1:0]   prev_row;
  logic [plane_width-1:0] plane_cnt, plane_nxt;
  logic                   have_prev;
  word_t                  shift_buf [hpixel_p];
  word_t                  line_buf  [hpixel_p];

  assign latch_ok = stb_rise && i_enable && (state == ST_IDLE);

  // Column counter saturates so surplus shift clocks never overwrite stored pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
    end else if (i_enable) begin
      if (stb_rise)
        col_cnt <= '0;
      else if (clk_rise && col_cnt != col_full)
        col_cnt <= col_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_enable && clk_rise && !stb_rise && col_cnt != col_full)
      shift_buf[col_cnt[idx_width-1:0]] <= word_in;
    if (latch_ok)
      line_buf <= shift_buf;
  end

  // Repeated latches of one row walk through the bit-planes; a new row restarts at 0.
  always_comb begin
    if (!have_prev || row_in != prev_row)
      plane_nxt = '0;
    else if (plane_cnt == plane_last)
      plane_nxt = '0;
    else
      plane_nxt = plane_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_row  <= '0;
      plane_cnt <= '0;
      have_prev <= 1'b0;
    end else if (!i_enable) begin
      have_prev <= 1'b0;
    end else if (latch_ok) begin
      prev_row  <= row_in;
      plane_cnt <= plane_nxt;
      have_prev <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_len_err <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (stb_rise && i_enable && col_cnt != col_full)
        o_len_err <= 1'b1;
      else if (i_err_clr)
        o_len_err <= 1'b0;
      if (stb_rise && i_enable && state == ST_DRAIN)
        o_overrun <= 1'b1;
      else if (i_err_clr)
        o_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      drain_col <= '0;
    end else begin
      state     <= state_nxt;
      drain_col <= drain_col_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_col_nxt = drain_col;
    unique case (state)
      ST_IDLE: begin
        if (latch_ok) begin
          state_nxt     = ST_DRAIN;
          drain_col_nxt = '0;
        end
      end
      ST_DRAIN: begin
        if (i_wr_ready) begin
          if (drain_col == col_last) begin
            state_nxt     = ST_IDLE;
            drain_col_nxt = '0;
          end else begin
            drain_col_nxt = drain_col + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write fields are zeroed outside DRAIN and only move on an accepted transfer.
  assign o_wr_valid = (state == ST_DRAIN);
  assign o_wr_addr  = o_wr_valid ? addr_width'(int'(prev_row) * hpixel_p + int'(drain_col)) : '0;
  assign o_wr_plane = o_wr_valid ? plane_cnt : '0;
  assign o_wr_data  = o_wr_valid ? line_buf[drain_col] : '0;

endmodule

// File: tb/tb_hub75_rx_capture.sv
`timescale 1ns/1ps
// Randomized self-checking bench for hub75_rx_capture with a line-level reference model.
module tb_hub75_rx_capture;

  logic clk = 1'b0;
  logic rst_n, i_enable, O_CLK, STB, OE, A, B, C, D, E;
  logic R1, G1, B1, R2, G2, B2, i_wr_ready, i_err_clr;
  logic        o_wr_valid, o_len_err, o_overrun;
  logic [11:0] o_wr_addr;
  logic [2:0]  o_wr_plane;
  logic [5:0]  o_wr_data;

  always #5 clk = ~clk;

  hub75_rx_capture dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .O_CLK(O_CLK), .STB(STB), .OE(OE),
    .A(A), .B(B), .C(C), .D(D), .E(E),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
    .o_wr_addr(o_wr_addr), .o_wr_plane(o_wr_plane), .o_wr_data(o_wr_data),
    .o_len_err(o_len_err), .o_overrun(o_overrun), .i_err_clr(i_err_clr)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [2:0]  plane;
    logic [5:0]  data;
  } wr_t;

  int   n_assert = 0, n_fail = 0;
  wr_t  got_q[$], exp_q[$];
  logic [5:0] px [64];
  int   m_have = 0, m_row = 0, m_plane = 0;
  int   cyc = 0, stb_cyc = 0, first_valid_cyc = 0, valid_cycles = 0;
  logic prev_valid = 1'b0, watch = 1'b0, unstable = 1'b0;
  logic [20:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && o_wr_valid && i_wr_ready)
      got_q.push_back({o_wr_addr, o_wr_plane, o_wr_data});
    if (o_wr_valid && !prev_valid) first_valid_cyc = cyc;
    if (o_wr_valid) valid_cycles++;
    prev_valid = o_wr_valid;
    if (watch && (o_wr_valid !== 1'b1 || {o_wr_addr, o_wr_plane, o_wr_data} !== snap))
      unstable = 1'b1;
  end

  // Reference: one accepted latch yields 64 writes of the latched line at the row's next plane.
  task automatic model_latch(input int row, input bit push);
    wr_t w;
    if (!m_have || row != m_row) m_plane = 0;
    else m_plane = (m_plane + 1) % 8;
    m_have = 1;
    m_row  = row;
    if (push)
      for (int k = 0; k < 64; k++) begin
        w.addr  = 12'(row * 64 + k);
        w.plane = 3'(m_plane);
        w.data  = px[k];
        exp_q.push_back(w);
      end
  endtask

  task automatic new_line();
    for (int k = 0; k < 64; k++) px[k] = 6'($urandom);
  endtask

  task automatic drive_pixel(input logic [5:0] w);
    {R2, G2, B2, R1, G1, B1} = w;
    OE = 1'($urandom_range(0, 1));
    repeat (2) @(posedge clk);
    #1 O_CLK = 1'b1;
    repeat (2) @(posedge clk);
    #1 O_CLK = 1'b0;
  endtask

  task automatic shift_line(input int n);
    for (int k = 0; k < n; k++) drive_pixel(k < 64 ? px[k] : 6'($urandom));
  endtask

  task automatic latch(input int row);
    {E, D, C, B, A} = 5'(row);
    repeat (2) @(posedge clk);
    #1 STB = 1'b1;
    stb_cyc = cyc;
    repeat (2) @(posedge clk);
    #1 STB = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (got_q.size() >= n && !o_wr_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic err_clear();
    @(posedge clk);
    #1 i_err_clr = 1'b1;
    @(posedge clk);
    #1 i_err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_enable = 1'b0; O_CLK = 1'b0; STB = 1'b0; OE = 1'b0;
    {E, D, C, B, A} = '0; {R2, G2, B2, R1, G1, B1} = '0;
    i_wr_ready = 1'b1; i_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++; if (o_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", o_wr_valid); end
    n_assert++; if (o_wr_addr !== 12'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, expected 0", o_wr_addr); end
    n_assert++; if (o_wr_plane !== 3'd0) begin n_fail++; $display("FAIL reset_plane: got %0d, expected 0", o_wr_plane); end
    n_assert++; if (o_wr_data !== 6'd0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", o_wr_data); end
    n_assert++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %b, expected 0", o_len_err); end
    n_assert++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", o_overrun); end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 i_enable = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    for (int k = 0; k < 64; k++) px[k] = {5'($urandom), 1'b0} | 6'((k & 1) << 2) | 6'($urandom & 3);
    shift_line(64);
    valid_cycles = 0;
    latch(5);
    model_latch(5, 1);
    wait_done(64, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got %0d writes, expected 64", got_q.size()); end
    n_assert++; if (first_valid_cyc - stb_cyc > 5 || first_valid_cyc - stb_cyc < 1) begin n_fail++; $display("FAIL basic_latency: got %0d cycles, expected 1..5", first_valid_cyc - stb_cyc); end
    n_assert++; if (valid_cycles != 64) begin n_fail++; $display("FAIL basic_drain_cycles: got %0d, expected 64", valid_cycles); end
    n_assert++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL basic_len_err: got %b, expected 0", o_len_err); end
    n_assert++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_wr[%0d]: got addr=%0d plane=%0d data=%h, expected addr=%0d plane=%0d data=%h", i, got_q[i].addr, got_q[i].plane, got_q[i].data, exp_q[i].addr, exp_q[i].plane, exp_q[i].data); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_planes();
    bit ok;
    @(posedge clk); #1 i_enable = 1'b0;
    m_have = 0;
    repeat (2) @(posedge clk); #1 i_enable = 1'b1;
    for (int n = 0; n < 9; n++) begin
      new_line();
      shift_line(64);
      latch(n < 8 ? 5 : 6);
      model_latch(n < 8 ? 5 : 6, 1);
      wait_done(64, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL planes_timeout[%0d]: got %0d writes, expected 64", n, got_q.size()); end
      n_assert++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL planes_count[%0d]: got %0d, expected %0d", n, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_assert++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL planes_wr[%0d][%0d]: got addr=%0d plane=%0d data=%h, expected addr=%0d plane=%0d data=%h", n, i, got_q[i].addr, got_q[i].plane, got_q[i].data, exp_q[i].addr, exp_q[i].plane, exp_q[i].data); end
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int row;
    row = $urandom_range(0, 31);
    new_line();
    shift_line(70);
    latch(row);
    model_latch(row, 1);
    n_assert++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL sat_len_err: got %b, expected 0", o_len_err); end
    wait_done(64, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: got %0d writes, expected 64", got_q.size()); end
    n_assert++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sat_wr[%0d]: got addr=%0d plane=%0d data=%h, expected addr=%0d plane=%0d data=%h", i, got_q[i].addr, got_q[i].plane, got_q[i].data, exp_q[i].addr, exp_q[i].plane, exp_q[i].data); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_len_err();
    bit ok;
    int row;
    row = $urandom_range(0, 31);
    new_line();
    shift_line(63);
    latch(row);
    model_latch(row, 0);
    n_assert++; if (o_len_err !== 1'b1) begin n_fail++; $display("FAIL len_err_set: got %b, expected 1", o_len_err); end
    n_assert++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL len_overrun: got %b, expected 0", o_overrun); end
    wait_done(64, ok);
    n_assert++; if (got_q.size() != 64) begin n_fail++; $display("FAIL len_drain_count: got %0d, expected 64", got_q.size()); end
    got_q.delete();
    n_assert++; if (o_len_err !== 1'b1) begin n_fail++; $display("FAIL len_err_sticky: got %b, expected 1", o_len_err); end
    err_clear();
    n_assert++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL len_err_clr: got %b, expected 0", o_len_err); end
  endtask

  task automatic test_overrun();
    bit ok;
    int row;
    row = $urandom_range(0, 31);
    i_wr_ready = 1'b0;
    new_line();
    shift_line(64);
    latch(row);
    model_latch(row, 1);
    for (int c = 0; c < 10 && !o_wr_valid; c++) begin @(posedge clk); #1; end
    n_assert++; if (o_wr_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b, expected 1", o_wr_valid); end
    snap = {o_wr_addr, o_wr_plane, o_wr_data};
    unstable = 1'b0;
    watch = 1'b1;
    new_line();
    shift_line(64);
    latch($urandom_range(0, 31));
    watch = 1'b0;
    n_assert++; if (o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b, expected 1", o_overrun); end
    n_assert++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL ovr_stable: got unstable=%b, expected 0", unstable); end
    n_assert++; if (o_wr_addr !== 12'(row * 64)) begin n_fail++; $display("FAIL ovr_hold_addr: got %0d, expected %0d", o_wr_addr, row * 64); end
    i_wr_ready = 1'b1;
    wait_done(64, ok);
    repeat (20) @(posedge clk);
    #1;
    n_assert++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovr_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovr_wr[%0d]: got addr=%0d plane=%0d data=%h, expected addr=%0d plane=%0d data=%h", i, got_q[i].addr, got_q[i].plane, got_q[i].data, exp_q[i].addr, exp_q[i].plane, exp_q[i].data); end
    end
    got_q.delete(); exp_q.delete();
    err_clear();
    n_assert++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b, expected 0", o_overrun); end
  endtask

  task automatic test_random_ready();
    bit ok;
    int row;
    row = $urandom_range(0, 1) ? m_row : $urandom_range(0, 31);
    new_line();
    shift_line(64);
    latch(row);
    model_latch(row, 1);
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(posedge clk);
      #1 i_wr_ready = 1'($urandom_range(0, 1));
      ok = (got_q.size() >= 64 && !o_wr_valid);
    end
    i_wr_ready = 1'b1;
    n_assert++; if (!ok) begin n_fail++; $display("FAIL rnd_timeout: got %0d writes, expected 64", got_q.size()); end
    n_assert++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_wr[%0d]: got addr=%0d plane=%0d data=%h, expected addr=%0d plane=%0d data=%h", i, got_q[i].addr, got_q[i].plane, got_q[i].data, exp_q[i].addr, exp_q[i].plane, exp_q[i].data); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_enable_fall();
    bit ok;
    int row;
    row = $urandom_range(0, 31);
    new_line();
    shift_line(64);
    latch(row);
    model_latch(row, 1);
    for (int c = 0; c < 10 && !o_wr_valid; c++) begin @(posedge clk); #1; end
    i_enable = 1'b0;
    wait_done(64, ok);
    n_assert++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL en_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL en_wr[%0d]: got addr=%0d plane=%0d data=%h, expected addr=%0d plane=%0d data=%h", i, got_q[i].addr, got_q[i].plane, got_q[i].data, exp_q[i].addr, exp_q[i].plane, exp_q[i].data); end
    end
    got_q.delete(); exp_q.delete();
    new_line();
    shift_line(64);
    latch(row);
    repeat (30) @(posedge clk);
    #1;
    n_assert++; if (got_q.size() != 0 || o_wr_valid !== 1'b0) begin n_fail++; $display("FAIL en_idle: got %0d writes valid=%b, expected 0 writes valid=0", got_q.size(), o_wr_valid); end
    n_assert++; if (o_len_err !== 1'b0 || o_overrun !== 1'b0) begin n_fail++; $display("FAIL en_flags: got len_err=%b overrun=%b, expected 0 0", o_len_err, o_overrun); end
    got_q.delete();
    i_enable = 1'b1;
    m_have = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int row;
    row = $urandom_range(0, 31);
    new_line();
    shift_line(64);
    latch(row);
    model_latch(row, 0);
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(posedge clk);
      #1 ok = (got_q.size() >= 20);
    end
    n_assert++; if (o_wr_addr !== 12'(row * 64 + 20)) begin n_fail++; $display("FAIL rstmid_col: got addr=%0d, expected %0d", o_wr_addr, row * 64 + 20); end
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if (o_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, expected 0", o_wr_valid); end
    n_assert++; if (o_wr_addr !== 12'd0 || o_wr_plane !== 3'd0) begin n_fail++; $display("FAIL rstmid_fields: got addr=%0d plane=%0d, expected 0 0", o_wr_addr, o_wr_plane); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    m_have = 0;
    row = (row == m_row) ? row : m_row;
    new_line();
    shift_line(64);
    latch(row);
    model_latch(row, 1);
    wait_done(64, ok);
    n_assert++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_wr[%0d]: got addr=%0d plane=%0d data=%h, expected addr=%0d plane=%0d data=%h", i, got_q[i].addr, got_q[i].plane, got_q[i].data, exp_q[i].addr, exp_q[i].plane, exp_q[i].data); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_planes();
    test_saturate();
    test_len_err();
    test_overrun();
    test_random_ready();
    test_random_ready();
    test_enable_fall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
